// File: rtl/frame_stream_driver_if.sv
// Bundle of the RAM and pixel-processor signals driven by frame_stream_driver.
// The master modport is the frame sequencer side; the slave modport is the
// environment side (source RAM, colour-correction processor, destination RAM).
interface frame_stream_driver_if #(
  parameter int ADDR_W = 19
);
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [23:0]       src_rdata;
  logic [23:0]       pix_rgb;
  logic              pix_valid;
  logic              pix_ready;
  logic [23:0]       res_rgb;
  logic              res_valid;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_addr;
  logic [23:0]       dst_wdata;

  modport master (
    output src_rd_en, src_addr,
    input  src_rdata,
    output pix_rgb, pix_valid,
    input  pix_ready, res_rgb, res_valid,
    output dst_wr_en, dst_addr, dst_wdata
  );

  modport slave (
    input  src_rd_en, src_addr,
    output src_rdata,
    input  pix_rgb, pix_valid,
    output pix_ready, res_rgb, res_valid,
    input  dst_wr_en, dst_addr, dst_wdata
  );
endinterface

// File: rtl/frame_stream_driver.sv
// Frame sequencer for the colour-correction pipeline. Walks a frame in raster
// order with one pixel in flight: read source RAM, hand the pixel to the
// processor, wait for the corrected result (or give up after TIMEOUT_CYCLES and
// write error red), then write it to the same address in destination RAM.
module frame_stream_driver #(
  parameter int IMAGE_WIDTH    = 768,
  parameter int IMAGE_HEIGHT   = 512,
  parameter int ADDR_W         = 19,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_matrix_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] pixel_count,
  frame_stream_driver_if.master bus
);

  localparam int XW = (IMAGE_WIDTH    > 1) ? $clog2(IMAGE_WIDTH)    : 1;
  localparam int YW = (IMAGE_HEIGHT   > 1) ? $clog2(IMAGE_HEIGHT)   : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_HEIGHT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0]   ERROR_RGB = 24'hFF0000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    SEND,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tmo_cnt;
  logic [23:0]       pix_rgb_q;
  logic [23:0]       dst_wdata_q;
  logic              start_ok;
  logic              tmo_hit;
  logic              last_pixel;

  assign start_ok   = start && cfg_matrix_valid;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // addr walks in step with x/y so it always equals y*IMAGE_WIDTH+x without a
  // multiplier; the same register addresses both the read and the write.
  assign bus.src_addr  = addr;
  assign bus.dst_addr  = addr;
  assign bus.pix_rgb   = pix_rgb_q;
  assign bus.dst_wdata = dst_wdata_q;

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the per-state strobes.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    frame_done    = 1'b0;
    bus.src_rd_en = 1'b0;
    bus.pix_valid = 1'b0;
    bus.dst_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = FETCH;
      end
      FETCH: begin
        busy          = 1'b1;
        bus.src_rd_en = 1'b1;
        state_next    = WAIT_DATA;
      end
      WAIT_DATA: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy          = 1'b1;
        bus.pix_valid = 1'b1;
        if (bus.pix_ready) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        busy = 1'b1;
        if (bus.res_valid || tmo_hit) state_next = WRITE;
      end
      WRITE: begin
        busy          = 1'b1;
        bus.dst_wr_en = 1'b1;
        state_next    = last_pixel ? DONE : FETCH;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel position, captured pixel data, timeout counter and frame status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      tmo_cnt     <= '0;
      pix_rgb_q   <= '0;
      dst_wdata_q <= '0;
      pixel_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            tmo_cnt     <= '0;
            pixel_count <= '0;
            timeout_err <= 1'b0;
          end
        end
        WAIT_DATA: begin
          pix_rgb_q <= bus.src_rdata;
          tmo_cnt   <= '0;
        end
        WAIT_RES: begin
          if (bus.res_valid) begin
            dst_wdata_q <= bus.res_rgb;
            tmo_cnt     <= '0;
          end else if (tmo_hit) begin
            dst_wdata_q <= ERROR_RGB;
            timeout_err <= 1'b1;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WRITE: begin
          pixel_count <= pixel_count + 1'b1;
          if (!last_pixel) begin
            addr <= addr + 1'b1;
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_stream_driver.sv
// Self-checking bench for frame_stream_driver on a 4x2 frame with a bench-side
// source RAM, a 3-cycle colour processor (result = ~input) and a scoreboard of
// expected destination writes.
module tb_frame_stream_driver;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int IW   = $clog2(NPIX);
  localparam int AW   = 19;
  localparam int TMO  = 16;
  localparam int LAT  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cfg_matrix_valid;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;
  logic [AW-1:0] pixel_count;

  frame_stream_driver_if #(.ADDR_W(AW)) bus ();

  frame_stream_driver #(
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .cfg_matrix_valid(cfg_matrix_valid),
    .busy            (busy),
    .frame_done      (frame_done),
    .timeout_err     (timeout_err),
    .pixel_count     (pixel_count),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            lat;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] mem [NPIX];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          hs_count = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          done_pulses = 0;
  int          resp_cnt = 0;
  logic [23:0] resp_data = '0;
  bit          rd_pending = 1'b0;
  int          rd_idx = 0;
  bit          prev_stalled = 1'b0;
  logic [23:0] prev_rgb = '0;
  int          silent_pix = -1;
  int          stall_pix = -1;
  int          stall_left = 0;
  bit          stray_in_send = 1'b0;

  function automatic logic [23:0] mem_at(input int i);
    if (i >= 0 && i < NPIX) return mem[i[IW-1:0]];
    return 'x;
  endfunction

  // One clock of the environment: source RAM, processor model, scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      sb.delete();
      resp_cnt      = 0;
      rd_pending    = 1'b0;
      prev_stalled  = 1'b0;
      bus.res_valid = 1'b0;
      bus.pix_ready = 1'b1;
      return;
    end
    if (bus.dst_wr_en === 1'b1) begin
      wr_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_write: got unexpected write addr=%0d data=%06h, expected no write",
                 bus.dst_addr, bus.dst_wdata);
      end else begin
        e = sb.pop_front();
        if (bus.dst_addr !== e.addr || bus.dst_wdata !== e.data || (cyc - e.cyc) != e.lat) begin
          miscompares++;
          $display("[TB] FAIL sb_write: got addr=%0d data=%06h lat=%0d, expected addr=%0d data=%06h lat=%0d",
                   bus.dst_addr, bus.dst_wdata, cyc - e.cyc, e.addr, e.data, e.lat);
        end
      end
    end
    if (bus.src_rd_en === 1'b1) rd_count++;
    if (frame_done === 1'b1) done_pulses++;
    if (prev_stalled) begin
      vectors++;
      if (bus.pix_valid !== 1'b1 || bus.pix_rgb !== prev_rgb) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got valid=%b rgb=%06h, expected valid=1 rgb=%06h",
                 bus.pix_valid, bus.pix_rgb, prev_rgb);
      end
    end
    bus.src_rdata = rd_pending ? mem_at(rd_idx) : 24'h5A5A5A;
    rd_pending    = (bus.src_rd_en === 1'b1);
    rd_idx        = int'(bus.src_addr);
    bus.res_valid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.res_valid = 1'b1;
        bus.res_rgb   = resp_data;
      end
    end
    if (bus.pix_valid === 1'b1 && hs_count == stall_pix && stall_left > 0) begin
      bus.pix_ready = 1'b0;
      stall_left--;
    end else begin
      bus.pix_ready = 1'b1;
    end
    if (stray_in_send && bus.pix_valid === 1'b1) begin
      bus.res_valid = 1'b1;
      bus.res_rgb   = 24'h123456;
    end
    if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
      vectors++;
      if (bus.pix_rgb !== mem_at(hs_count)) begin
        miscompares++;
        $display("[TB] FAIL pix_rgb: got %06h, expected %06h at pixel %0d",
                 bus.pix_rgb, mem_at(hs_count), hs_count);
      end
      e.addr = AW'(hs_count);
      e.cyc  = cyc;
      if (hs_count == silent_pix) begin
        e.data = 24'hFF0000;
        e.lat  = TMO + 1;
      end else begin
        e.data    = ~mem_at(hs_count);
        e.lat     = LAT + 1;
        resp_cnt  = LAT;
        resp_data = ~bus.pix_rgb;
      end
      sb.push_back(e);
      hs_count++;
    end
    prev_stalled = (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b0);
    prev_rgb     = bus.pix_rgb;
  endtask

  task automatic begin_frame();
    for (int i = 0; i < NPIX; i++) mem[i] = 24'($urandom);
    hs_count    = 0;
    wr_count    = 0;
    rd_count    = 0;
    done_pulses = 0;
    tick();
    start            = 1'b1;
    cfg_matrix_valid = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    start            = 1'b0;
    cfg_matrix_valid = 1'b0;
    bus.src_rdata    = '0;
    bus.pix_ready    = 1'b1;
    bus.res_rgb      = '0;
    bus.res_valid    = 1'b0;
    repeat (3) tick();
    #1;
    vectors++;
    if ({busy, frame_done, timeout_err, pixel_count, bus.src_rd_en, bus.src_addr, bus.pix_rgb,
         bus.pix_valid, bus.dst_wr_en, bus.dst_addr, bus.dst_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b terr=%b cnt=%0d, expected all 0",
               busy, frame_done, timeout_err, pixel_count);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || bus.src_rd_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got busy=%b rd=%b, expected 0 0", busy, bus.src_rd_en);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    begin_frame();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_start: got %b, expected 1", busy);
    end
    wait_done(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got no frame_done, expected one within 400 cycles");
    end
    vectors++;
    if (done_pulses != 1 || wr_count != NPIX || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_summary: got pulses=%0d writes=%0d busy=%b, expected 1 %0d 0",
               done_pulses, wr_count, busy, NPIX);
    end
    vectors++;
    if (pixel_count !== AW'(NPIX) || timeout_err !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_count: got cnt=%0d terr=%b pending=%0d, expected %0d 0 0",
               pixel_count, timeout_err, sb.size(), NPIX);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    stall_pix  = 1;
    stall_left = 5;
    begin_frame();
    wait_done(ok);
    stall_pix = -1;
    vectors++;
    if (!ok || hs_count != NPIX || wr_count != NPIX || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_frame: got done=%b handshakes=%0d writes=%0d, expected 1 %0d %0d",
               ok, hs_count, wr_count, NPIX, NPIX);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    silent_pix = 2;
    begin_frame();
    wait_done(ok);
    silent_pix = -1;
    vectors++;
    if (!ok || timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_flag: got done=%b terr=%b, expected 1 1", ok, timeout_err);
    end
    vectors++;
    if (pixel_count !== AW'(NPIX) || wr_count != NPIX || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_count: got cnt=%0d writes=%0d, expected %0d %0d",
               pixel_count, wr_count, NPIX, NPIX);
    end
  endtask

  task automatic test_start_gating();
    bit ok;
    rd_count = 0;
    tick();
    start            = 1'b1;
    cfg_matrix_valid = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    vectors++;
    if (busy !== 1'b0 || rd_count != 0 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_no_cfg: got busy=%b reads=%0d terr=%b, expected 0 0 1",
               busy, rd_count, timeout_err);
    end
    begin_frame();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL terr_clear: got %b, expected 0", timeout_err);
    end
    repeat (20) tick();
    start            = 1'b1;
    cfg_matrix_valid = 1'b0;
    tick();
    start = 1'b0;
    wait_done(ok);
    vectors++;
    if (!ok || done_pulses != 1 || wr_count != NPIX || pixel_count !== AW'(NPIX) || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL start_midframe: got done=%b pulses=%0d writes=%0d cnt=%0d, expected 1 1 %0d %0d",
               ok, done_pulses, wr_count, pixel_count, NPIX, NPIX);
    end
  endtask

  task automatic test_stray_res();
    bit ok;
    wr_count = 0;
    tick();
    bus.res_valid = 1'b1;
    bus.res_rgb   = 24'h0F0F0F;
    repeat (3) tick();
    vectors++;
    if (wr_count != 0 || pixel_count !== AW'(NPIX) || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stray_idle: got writes=%0d cnt=%0d busy=%b, expected 0 %0d 0",
               wr_count, pixel_count, busy, NPIX);
    end
    stray_in_send = 1'b1;
    stall_pix     = 3;
    stall_left    = 2;
    begin_frame();
    wait_done(ok);
    stray_in_send = 1'b0;
    stall_pix     = -1;
    vectors++;
    if (!ok || wr_count != NPIX || pixel_count !== AW'(NPIX) || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stray_send: got done=%b writes=%0d cnt=%0d, expected 1 %0d %0d",
               ok, wr_count, pixel_count, NPIX, NPIX);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit reached;
    reached = 1'b0;
    begin_frame();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hs_count >= 4) begin
        reached = 1'b1;
        break;
      end
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("[TB] FAIL reach_pixel3: got %0d handshakes, expected 4 within 200 cycles", hs_count);
    end
    tick();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, frame_done, timeout_err, pixel_count, bus.src_rd_en, bus.src_addr, bus.pix_rgb,
         bus.pix_valid, bus.dst_wr_en, bus.dst_addr, bus.dst_wdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got busy=%b cnt=%0d addr=%0d wdata=%06h, expected all 0",
               busy, pixel_count, bus.dst_addr, bus.dst_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.src_rd_en, bus.pix_valid, bus.dst_wr_en} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL reset_strobes: got rd=%b valid=%b wr=%b, expected 0 0 0",
                 bus.src_rd_en, bus.pix_valid, bus.dst_wr_en);
      end
    end
    rst_n = 1'b1;
    begin_frame();
    wait_done(ok);
    vectors++;
    if (!ok || done_pulses != 1 || wr_count != NPIX || pixel_count !== AW'(NPIX) || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL restart_frame: got done=%b pulses=%0d writes=%0d cnt=%0d, expected 1 1 %0d %0d",
               ok, done_pulses, wr_count, pixel_count, NPIX, NPIX);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ready_stall();
    test_timeout();
    test_start_gating();
    test_stray_res();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running at 200000, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
